// File: rtl/sram_rd_pkg.sv
// Shared types and width helpers for the SRAM read streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Default SRAM address width and the matching word-count width. The count
  // needs one extra bit so a full-depth window (2**ADDR_WIDTH) is encodable.
  localparam int SRAM_ADDR_WIDTH = 5;
  localparam int CNT_WIDTH       = SRAM_ADDR_WIDTH + 1;

  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible on pop_data.
// Latency: a word pushed at edge N is readable after edge N.
// Backpressure: push is ignored when full (unless popping the same edge); pop is ignored when empty.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset (clears pointers/count)
//   push, push_data       write strobe and word
//   pop                   consume the head entry
//   pop_data              head entry (valid while empty=0)
//   empty                 no entries held
//   count                 current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop on the same edge frees the slot the push needs.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sram_rd_streamer.sv
// Sweeps a contiguous SRAM window on start and streams the words out valid/ready.
// Latency: start at edge E0 -> read of base at E1 -> m_valid high after E2; then 1 word/cycle.
// Backpressure: reads are credit-gated on FIFO occupancy + in-flight read; m_data/m_last hold while stalled.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, base_addr, length      command (sampled in IDLE only); length 0..2**ADDR_WIDTH
//   busy, done                    busy from accepted start to done; done = 1-cycle pulse
//   sram_en_n, sram_wren_n        SRAM strobes, active low (write never asserted)
//   sram_addr, sram_rdata         SRAM address / read data (1-cycle read latency)
//   m_valid, m_data, m_last       output stream
//   m_ready                       downstream accept
import sram_rd_pkg::*;

module sram_rd_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_en_n,
  output logic                  sram_wren_n,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int CW  = cnt_width(ADDR_WIDTH);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [CW-1:0]         remaining;
  logic                  pend;
  logic                  pend_last;
  logic                  done_r;

  logic [FCW-1:0]        fifo_count;
  logic [FCW:0]          occ;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_head;
  logic                  issue;
  logic                  pop;
  logic                  last_pop;
  logic                  start_run;
  logic                  start_zero;

  assign start_run  = (state == IDLE) && start && (length != '0);
  assign start_zero = (state == IDLE) && start && (length == '0);

  // Credit rule: an in-flight read already owns a FIFO slot, so count it
  // alongside the stored words before issuing another.
  assign occ   = {1'b0, fifo_count} + {{FCW{1'b0}}, pend};
  assign issue = (state == RUN) && (occ < (FCW + 1)'(FIFO_DEPTH));

  assign pop      = m_valid && m_ready;
  assign last_pop = pop && fifo_head[DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_run) state_nxt = RUN;
      RUN:     if (issue && (remaining == CW'(1))) state_nxt = DRAIN;
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clearing pend on reset is what drops a read that was in flight when
  // the sweep was aborted.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      addr_hold <= '0;
      remaining <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      pend      <= issue;
      pend_last <= issue && (remaining == CW'(1));
      done_r    <= start_zero || ((state == DRAIN) && last_pop);
      if (start_run) begin
        addr      <= base_addr;
        remaining <= length;
      end else if (issue) begin
        addr      <= addr + ADDR_WIDTH'(1);
        remaining <= remaining - CW'(1);
        addr_hold <= addr;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH),
    .CW    (FCW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pend),
    .push_data ({pend_last, sram_rdata}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // addr already points past the last issued word, so the bus shows the
  // held copy between issues.
  assign sram_en_n   = ~issue;
  assign sram_wren_n = 1'b1;
  assign sram_addr   = issue ? addr : addr_hold;

  assign busy    = (state != IDLE);
  assign done    = done_r;
  assign m_valid = ~fifo_empty;
  assign m_data  = fifo_head[DATA_WIDTH-1:0];
  assign m_last  = fifo_head[DATA_WIDTH] & ~fifo_empty;

endmodule

// File: tb/tb_sram_rd_streamer.sv
module tb_sram_rd_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  base_addr = '0;
  logic [5:0]  length = '0;
  logic        busy, done, sram_en_n, sram_wren_n;
  logic [4:0]  sram_addr;
  logic [15:0] sram_rdata = '0;
  logic        m_valid, m_last;
  logic [15:0] m_data;
  logic        m_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  sram_rd_streamer #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .sram_en_n(sram_en_n), .sram_wren_n(sram_wren_n),
    .sram_addr(sram_addr), .sram_rdata(sram_rdata), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // SRAM model: mem[i] = i*3, one-cycle read latency.
  logic [15:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = 16'(i * 3);
  always @(posedge clk) if (!sram_en_n) sram_rdata <= mem[sram_addr];

  // Port monitor, sampled mid-cycle.
  int          cyc = 0;
  int          en_cnt, done_cnt, done_cyc, first_pop, last_pop_cyc;
  int          outstanding, max_out, stall_viol, stall_seen;
  bit          busy_seen, prev_stall;
  logic [15:0] prev_data;
  logic        prev_last;
  logic [15:0] words [$];
  logic        lasts [$];
  logic [4:0]  addrs [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!sram_en_n) begin
      en_cnt++;
      addrs.push_back(sram_addr);
      outstanding++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_seen = 1'b1;
    if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stall_viol++;
    if (m_valid && m_ready) begin
      words.push_back(m_data);
      lasts.push_back(m_last);
      if (first_pop < 0) first_pop = cyc;
      last_pop_cyc = cyc;
      outstanding--;
    end
    if (m_valid && !m_ready) stall_seen++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    if (outstanding > max_out) max_out = outstanding;
    if (rst) outstanding = 0;
  end

  task automatic clr();
    en_cnt = 0; done_cnt = 0; done_cyc = -1; first_pop = -1; last_pop_cyc = -1;
    outstanding = 0; max_out = 0; stall_viol = 0; stall_seen = 0;
    busy_seen = 1'b0; prev_stall = 1'b0;
    words.delete(); lasts.delete(); addrs.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input int b, input int n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 5'(b); length = 6'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit bp);
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 400; i++) begin
      if (done_cnt != 0) break;
      @(posedge clk); #1;
      if (bp) m_ready = ((i % 7) < 4) ? pat[i % 4] : 1'($urandom_range(0, 1));
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_seen"}, 32'(done_cnt != 0), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Words expected from a window starting at b, n long (addresses wrap).
  task automatic chk_stream(input string tag, input int b, input int n);
    chk({tag, "_count"}, words.size(), n);
    for (int i = 0; i < n && i < words.size(); i++) begin
      chk($sformatf("%s_w%0d", tag, i), words[i], 32'(((b + i) % 32) * 3));
      chk($sformatf("%s_l%0d", tag, i), lasts[i], 32'(i == n - 1));
    end
  endtask

  initial begin
    clr();
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en_n", sram_en_n, 1);
    chk("rst_wren_n", sram_wren_n, 1);
    chk("rst_addr", sram_addr, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Basic: base 4, length 5 -> 12,15,18,21,24
    clr();
    start_cmd(4, 5);
    @(negedge clk);
    chk("lat_busy", busy, 1);
    chk("lat_en_n", sram_en_n, 0);
    chk("lat_addr", sram_addr, 4);
    chk("lat_valid0", m_valid, 0);
    @(negedge clk);
    chk("lat_valid1", m_valid, 0);
    @(negedge clk);
    chk("lat_valid2", m_valid, 1);
    chk("lat_data2", m_data, 12);
    wait_done("basic", 1'b0);
    idle(3);
    chk("basic_n", words.size(), 5);
    if (words.size() == 5) begin
      chk("basic_w0", words[0], 12);
      chk("basic_w1", words[1], 15);
      chk("basic_w2", words[2], 18);
      chk("basic_w3", words[3], 21);
      chk("basic_w4", words[4], 24);
      chk("basic_l3", lasts[3], 0);
      chk("basic_l4", lasts[4], 1);
    end
    chk("basic_en_cycles", en_cnt, 5);
    chk("basic_done_delay", done_cyc - last_pop_cyc, 1);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_contig", last_pop_cyc - first_pop, 4);
    chk("basic_idle_en_n", sram_en_n, 1);
    chk("basic_hold_addr", sram_addr, 8);

    // Wrap: base 30, length 4
    clr();
    start_cmd(30, 4);
    wait_done("wrap", 1'b0);
    idle(2);
    chk("wrap_naddr", addrs.size(), 4);
    if (addrs.size() == 4) begin
      chk("wrap_a0", addrs[0], 30);
      chk("wrap_a1", addrs[1], 31);
      chk("wrap_a2", addrs[2], 0);
      chk("wrap_a3", addrs[3], 1);
    end
    if (words.size() == 4) begin
      chk("wrap_w0", words[0], 90);
      chk("wrap_w1", words[1], 93);
      chk("wrap_w2", words[2], 0);
      chk("wrap_w3", words[3], 3);
    end
    chk("wrap_n", words.size(), 4);

    // Backpressure: length 8 from base 20, m_ready toggling
    clr();
    start_cmd(20, 8);
    wait_done("bp", 1'b1);
    idle(2);
    chk_stream("bp", 20, 8);
    chk("bp_stable", stall_viol, 0);
    chk("bp_stalled", 32'(stall_seen > 0), 1);
    chk("bp_credit", 32'(max_out <= 4), 1);
    chk("bp_done_cnt", done_cnt, 1);

    // Full depth: length 32 from base 0
    clr();
    start_cmd(0, 32);
    wait_done("full", 1'b0);
    idle(2);
    chk_stream("full", 0, 32);
    chk("full_en_cycles", en_cnt, 32);
    chk("full_contig", last_pop_cyc - first_pop, 31);

    // Zero length
    clr();
    start_cmd(7, 0);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    idle(3);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_en", en_cnt, 0);
    chk("zero_busy_seen", 32'(busy_seen), 0);
    chk("zero_words", words.size(), 0);

    // Reset mid-sweep: length 10 from base 5, reset after 3 words
    clr();
    start_cmd(5, 10);
    for (int i = 0; i < 100 && words.size() < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("mrst_reached3", 32'(words.size() >= 3), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid", m_valid, 0);
    chk("mrst_en_n", sram_en_n, 1);
    chk("mrst_busy", busy, 0);
    idle(5);
    chk("mrst_no_done", done_cnt, 0);
    chk("mrst_no_valid", m_valid, 0);
    clr();
    start_cmd(0, 2);
    wait_done("mrst2", 1'b0);
    idle(4);
    chk_stream("mrst2", 0, 2);

    // Start while busy is ignored
    clr();
    start_cmd(10, 6);
    idle(1);
    start_cmd(0, 3);
    wait_done("sbusy", 1'b0);
    idle(6);
    chk("sbusy_done_cnt", done_cnt, 1);
    chk("sbusy_en", en_cnt, 6);
    chk_stream("sbusy", 10, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_rd_streamer.md
Name: sram_rd_streamer

Overview:
- Read-side controller placed directly downstream of the single-port feature/weight SRAM.
- On a start command it sweeps a contiguous address window, handles the SRAM's 1-cycle read latency, and presents the words as a valid/ready stream to the compute stage.
- A small internal FIFO absorbs backpressure, so no read data is ever lost or duplicated.

Parameters:
- DATA_WIDTH, 16, SRAM word width.
- ADDR_WIDTH, 5, SRAM address width (depth 2**ADDR_WIDTH).
- FIFO_DEPTH, 4, output buffer entries; must be >=3 to sustain 1 word/cycle.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe, sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first address of window.
- length  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the last word is accepted downstream.
- sram_en_n  out  1  SRAM enable, active low.
- sram_wren_n  out  1  SRAM write enable, active low; tied to 1 (read-only master).
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_rdata  in  DATA_WIDTH  SRAM data_o; valid the cycle after an enabled read edge.
- m_valid  out  1  stream word valid.
- m_data  out  DATA_WIDTH  stream word.
- m_last  out  1  marks final word of window; qualified by m_valid.
- m_ready  in  1  downstream accept.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, sram_en_n=1, sram_wren_n=1, sram_addr=0, m_valid=0, m_last=0. The FIFO and pending counters are cleared.
- Reset mid-operation aborts the sweep. No done pulse is generated, and stale SRAM data arriving after reset is discarded.
- States:
  - IDLE -> RUN: start=1 and length!=0. Latch addr=base_addr, remaining=length.
  - IDLE, start=1 and length=0: done pulses on the next cycle; stay in IDLE; busy stays 0.
  - RUN: a read is issued in a cycle when (fifo_count + pend) < FIFO_DEPTH. An issued read drives sram_en_n=0 and sram_addr=addr, combinational from state registers. Each issue increments addr by 1 and decrements remaining.
  - RUN -> DRAIN: on the edge issuing the read with remaining=1.
  - DRAIN -> IDLE: on the edge where the m_last word is popped (m_valid & m_ready & m_last). done=1 for the following cycle.
- pend = reads issued but not yet written into the FIFO; range 0..1.
- A word issued at edge N is on sram_rdata after N and is written into the FIFO at edge N+1. The word tagged last is also flagged in the FIFO.
- m_valid = FIFO not empty. m_data and m_last come from the FIFO head. A pop occurs on m_valid & m_ready.
- Latency: start sampled at edge E0 -> SRAM read of base at E1 -> m_valid=1 in the cycle after E2.
- Throughput: with m_ready held at 1, one word per cycle, with no bubbles after the first word.
- Backpressure: m_data and m_last are held stable while m_valid=1 and m_ready=0. Issue stalls under the credit rule, and sram_en_n=1 during a stall.
- Address arithmetic is modulo 2**ADDR_WIDTH. base_addr+length beyond the top wraps to 0.
- length=2**ADDR_WIDTH reads every location exactly once.
- start while busy=1 is ignored.
- A simultaneous FIFO push and pop in the same cycle keeps fifo_count unchanged.
- When not issuing, sram_en_n=1 and sram_addr holds its last value.

Decomposition:
- Shared package sram_rd_pkg contains:
  - State enum {IDLE, RUN, DRAIN}.
  - Localparam for the count width (ADDR_WIDTH+1).
- One sub-module: sync_fifo. It is a parameterised, synchronous-reset, first-word-fall-through FIFO of width DATA_WIDTH+1 (data plus last flag) and depth FIFO_DEPTH. It exposes count for the credit rule.

Test Plan:
- Basic: mem[i]=i*3; start, base=4, length=5, m_ready=1 -> stream 12,15,18,21,24. m_last only on 24. done 1 cycle after the last pop. Exactly 5 cycles with sram_en_n=0.
- Wrap: base=30, length=4 -> addresses 30,31,0,1 in order. Stream equals mem[30],mem[31],mem[0],mem[1].
- Backpressure: length=8, m_ready toggled 1,0,0,1 randomly -> all 8 words delivered in order with no duplicates. m_data stable while stalled. pend+fifo_count never exceeds 4.
- Full and zero length:
  - length=32 from base=0 -> 32 words, 32 contiguous output cycles after the first.
  - length=0 -> no SRAM access, busy=0, done pulse only.
- Reset mid-sweep: rst asserted after 3 words of a length=10 sweep -> next cycle m_valid=0, sram_en_n=1, busy=0, no done. A new start base=0, length=2 then delivers mem[0],mem[1] only.
- Start while busy: a second start pulse mid-sweep -> ignored. Exactly one done; word count equals the first length.
